// File: rtl/pwr_seq_nrail.sv
// Parametrised N-rail power sequencer.
// Rails come up in ascending index order and go down in descending order.
// Each rail waits a per-rail delay, then toggles its enable and waits for a
// power-good handshake. PG timeouts, PG dropouts and emergency shutdowns latch
// a fault and drop every enable at once.
module pwr_seq_nrail #(
  parameter int NUM_RAILS = 4,
  parameter int DLY_W     = 16,
  parameter int TICK_DIV  = 2000,
  parameter int PG_TMO    = 100
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iAux_Good,
  input  logic                       iPwr_Req,
  input  logic                       iShutdown_N,
  input  logic                       iLatch_Clear,
  input  logic [NUM_RAILS*DLY_W-1:0] iRail_Dly,
  input  logic [NUM_RAILS-1:0]       iRail_PG,
  output logic [NUM_RAILS-1:0]       oRail_EN,
  output logic                       oPwr_Done,
  output logic                       oFault,
  output logic [1:0]                 oFault_Type,
  output logic [2:0]                 oFault_Rail,
  output logic [3:0]                 oFSM_State
);

  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMO_W = $clog2(PG_TMO + 1);
  // The tick counter has to reach both the longest delay and the PG timeout.
  localparam int CNT_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ON_DLY  = 4'd1,
    ON_PG   = 4'd2,
    RUN     = 4'd3,
    OFF_DLY = 4'd4,
    OFF_PG  = 4'd5,
    FAULT   = 4'd6
  } state_t;

  typedef enum logic [1:0] {
    FT_NONE  = 2'b00,
    FT_TMO   = 2'b01,
    FT_DROP  = 2'b10,
    FT_EMERG = 2'b11
  } fault_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     k, k_next;
  logic [NUM_RAILS-1:0] rail_en, en_next;
  logic                 pwr_done;
  logic                 fault, fault_next;
  fault_t               fault_type, type_next;
  logic [2:0]           fault_rail, rail_next;
  logic [PRE_W-1:0]     presc;
  logic [CNT_W-1:0]     tick_cnt;
  logic [DLY_W-1:0]     dly_q;

  logic [DLY_W-1:0]     dly_arr [NUM_RAILS];
  logic                 tick;
  logic [CNT_W:0]       cnt_inc;
  logic                 dly_done;
  logic                 tmo_done;
  logic                 pg_k;
  logic                 emerg;
  logic [NUM_RAILS-1:0] drop_mask;
  logic [2:0]           drop_idx;
  logic                 any_en;
  logic [IDX_W-1:0]     hi_idx;
  logic                 raise;
  fault_t               raise_type;
  logic [2:0]           raise_rail;

  // Unpack the flat delay bus and derive tick, delay and timeout conditions.
  always_comb begin
    for (int i = 0; i < NUM_RAILS; i++) begin
      dly_arr[i] = iRail_Dly[i*DLY_W +: DLY_W];
    end
    tick     = (presc == PRE_W'(TICK_DIV - 1));
    cnt_inc  = {1'b0, tick_cnt} + (CNT_W+1)'(1);
    // A zero delay still costs one cycle in the delay state.
    dly_done = (dly_q == '0) || (tick && (cnt_inc == (CNT_W+1)'(dly_q)));
    tmo_done = tick && (cnt_inc == (CNT_W+1)'(PG_TMO));
    pg_k     = iRail_PG[k];
    emerg    = !iShutdown_N || !iAux_Good;
  end

  // Find the lowest dropped-out rail and the highest currently enabled rail.
  always_comb begin
    drop_mask = rail_en & ~iRail_PG;
    if (state == ON_PG) drop_mask[k] = 1'b0;
    drop_idx = 3'd0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (drop_mask[j]) drop_idx = 3'(j);
    end
    any_en = |rail_en;
    hi_idx = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if (rail_en[j]) hi_idx = IDX_W'(j);
    end
  end

  // Next-state, rail-enable and fault-latch logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    k_next     = k;
    en_next    = rail_en;
    fault_next = fault;
    type_next  = fault_type;
    rail_next  = fault_rail;
    raise      = 1'b0;
    raise_type = FT_NONE;
    raise_rail = 3'd0;

    case (state)
      IDLE: begin
        if (iAux_Good && iPwr_Req && iShutdown_N) begin
          k_next     = '0;
          state_next = ON_DLY;
        end
      end

      FAULT: begin
        if (iLatch_Clear && iShutdown_N) begin
          fault_next = 1'b0;
          type_next  = FT_NONE;
          rail_next  = 3'd0;
          state_next = IDLE;
        end
      end

      default: begin
        if (emerg) begin
          raise      = 1'b1;
          raise_type = FT_EMERG;
        end else if ((state inside {ON_DLY, ON_PG, RUN}) && (|drop_mask)) begin
          raise      = 1'b1;
          raise_type = FT_DROP;
          raise_rail = drop_idx;
        end else begin
          case (state)
            ON_DLY, ON_PG: begin
              if (!iPwr_Req) begin
                // Abort: unwind from the highest rail already enabled.
                if (any_en) begin
                  k_next     = hi_idx;
                  state_next = OFF_DLY;
                end else begin
                  state_next = IDLE;
                end
              end else if (state == ON_DLY) begin
                if (dly_done) begin
                  en_next[k] = 1'b1;
                  state_next = ON_PG;
                end
              end else if (pg_k) begin
                if (k == IDX_W'(NUM_RAILS - 1)) begin
                  state_next = RUN;
                end else begin
                  k_next     = k + IDX_W'(1);
                  state_next = ON_DLY;
                end
              end else if (tmo_done) begin
                raise      = 1'b1;
                raise_type = FT_TMO;
                raise_rail = 3'(k);
              end
            end
            RUN: begin
              if (!iPwr_Req) begin
                k_next     = IDX_W'(NUM_RAILS - 1);
                state_next = OFF_DLY;
              end
            end
            OFF_DLY: begin
              if (dly_done) begin
                en_next[k] = 1'b0;
                state_next = OFF_PG;
              end
            end
            OFF_PG: begin
              if (!pg_k) begin
                if (k == '0) begin
                  state_next = IDLE;
                end else begin
                  k_next     = k - IDX_W'(1);
                  state_next = OFF_DLY;
                end
              end else if (tmo_done) begin
                raise      = 1'b1;
                raise_type = FT_TMO;
                raise_rail = 3'(k);
              end
            end
            default: begin
              en_next    = '0;
              state_next = IDLE;
            end
          endcase
        end
      end
    endcase

    if (raise) begin
      en_next    = '0;
      fault_next = 1'b1;
      type_next  = raise_type;
      rail_next  = raise_rail;
      state_next = FAULT;
    end
  end

  // State, enables, fault latch, prescaler and delay counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      k          <= '0;
      rail_en    <= '0;
      pwr_done   <= 1'b0;
      fault      <= 1'b0;
      fault_type <= FT_NONE;
      fault_rail <= 3'd0;
      presc      <= '0;
      tick_cnt   <= '0;
      dly_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      k          <= k_next;
      rail_en    <= en_next;
      pwr_done   <= (state_next == RUN);
      fault      <= fault_next;
      fault_type <= type_next;
      fault_rail <= rail_next;
      if (state_next != state) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + CNT_W'(1);
      end else begin
        presc    <= presc + PRE_W'(1);
      end
      // Delay is captured on entry, so a live change only affects later rails.
      if ((state_next inside {ON_DLY, OFF_DLY}) && (state_next != state)) begin
        dly_q <= dly_arr[k_next];
      end
    end
  end

  assign oRail_EN    = rail_en;
  assign oPwr_Done   = pwr_done;
  assign oFault      = fault;
  assign oFault_Type = fault_type;
  assign oFault_Rail = fault_rail;
  assign oFSM_State  = state;

endmodule

// File: tb/tb_pwr_seq_nrail.sv
// Testbench for pwr_seq_nrail: directed scenarios plus randomised up/down rounds.
// Expected edge times come from the timing rules: a delay of D ticks ends
// D*TICK_DIV cycles after the delay state is entered (one cycle for D=0), and
// each delay state is entered on the edge that samples the previous PG change.
module tb_pwr_seq_nrail;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int TD  = 4;
  localparam int TMO = 5;

  logic            iClk = 1'b0;
  logic            iRst;
  logic            iAux_Good;
  logic            iPwr_Req;
  logic            iShutdown_N;
  logic            iLatch_Clear;
  logic [NR*DW-1:0] iRail_Dly;
  logic [NR-1:0]   iRail_PG;
  logic [NR-1:0]   oRail_EN;
  logic            oPwr_Done;
  logic            oFault;
  logic [1:0]      oFault_Type;
  logic [2:0]      oFault_Rail;
  logic [3:0]      oFSM_State;

  pwr_seq_nrail #(
    .NUM_RAILS(NR), .DLY_W(DW), .TICK_DIV(TD), .PG_TMO(TMO)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iAux_Good(iAux_Good), .iPwr_Req(iPwr_Req),
    .iShutdown_N(iShutdown_N), .iLatch_Clear(iLatch_Clear),
    .iRail_Dly(iRail_Dly), .iRail_PG(iRail_PG), .oRail_EN(oRail_EN),
    .oPwr_Done(oPwr_Done), .oFault(oFault), .oFault_Type(oFault_Type),
    .oFault_Rail(oFault_Rail), .oFSM_State(oFSM_State)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_rise_cyc [NR];
  int en_fall_cyc [NR];
  int pg_rise_cyc [NR];
  int pg_fall_cyc [NR];
  int dly [NR];
  logic [NR-1:0] en_hist [8];
  int pg_lag = 2;
  logic [NR-1:0] pg_force_low = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dly_cycles(input int d);
    return (d == 0) ? 1 : d * TD;
  endfunction

  task automatic set_dly();
    for (int i = 0; i < NR; i++) iRail_Dly[i*DW +: DW] = DW'(dly[i]);
  endtask

  // One clock: sample #1 after the edge, log EN/PG edges, drive PG as a lagged copy of EN.
  task automatic step();
    logic [NR-1:0] prev_en;
    logic [NR-1:0] prev_pg;
    prev_en = oRail_EN;
    @(posedge iClk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (!prev_en[i] && oRail_EN[i]) en_rise_cyc[i] = cyc;
      if (prev_en[i] && !oRail_EN[i]) en_fall_cyc[i] = cyc;
    end
    for (int i = 7; i > 0; i--) en_hist[i] = en_hist[i-1];
    en_hist[0] = oRail_EN;
    prev_pg  = iRail_PG;
    iRail_PG = en_hist[pg_lag-1] & ~pg_force_low;
    for (int i = 0; i < NR; i++) begin
      if (!prev_pg[i] && iRail_PG[i]) pg_rise_cyc[i] = cyc;
      if (prev_pg[i] && !iRail_PG[i]) pg_fall_cyc[i] = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_en(input int k, input logic want);
    int n = 0;
    while (oRail_EN[k] !== want && n < 200) begin step(); n++; end
    if (oRail_EN[k] !== want) check($sformatf("wait en%0d", k), 32'(oRail_EN[k]), 32'(want));
  endtask

  task automatic wait_pg(input int k, input logic want);
    int n = 0;
    while (iRail_PG[k] !== want && n < 200) begin step(); n++; end
    if (iRail_PG[k] !== want) check($sformatf("wait pg%0d", k), 32'(iRail_PG[k]), 32'(want));
  endtask

  task automatic power_up();
    int entry;
    iPwr_Req = 1'b1;
    entry = cyc + 1;
    for (int k = 0; k < NR; k++) begin
      wait_en(k, 1'b1);
      check($sformatf("en%0d rise cycle", k), en_rise_cyc[k], entry + dly_cycles(dly[k]));
      wait_pg(k, 1'b1);
      entry = pg_rise_cyc[k] + 1;
    end
    check("pre-run state", 32'(oFSM_State), 32'd2);
    check("pre-run done", 32'(oPwr_Done), 32'd0);
    step();
    check("run state", 32'(oFSM_State), 32'd3);
    check("run done", 32'(oPwr_Done), 32'd1);
    check("run enables", 32'(oRail_EN), 32'hF);
  endtask

  task automatic power_down();
    int entry;
    iPwr_Req = 1'b0;
    entry = cyc + 1;
    step();
    check("pd state", 32'(oFSM_State), 32'd4);
    check("pd done", 32'(oPwr_Done), 32'd0);
    for (int k = NR - 1; k >= 0; k--) begin
      wait_en(k, 1'b0);
      check($sformatf("en%0d fall cycle", k), en_fall_cyc[k], entry + dly_cycles(dly[k]));
      wait_pg(k, 1'b0);
      entry = pg_fall_cyc[k] + 1;
    end
    step();
    check("pd idle", 32'(oFSM_State), 32'd0);
    check("pd no fault", 32'(oFault), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e1;
    int n;
    int a;
    iRst = 1'b1; iAux_Good = 1'b1; iPwr_Req = 1'b0; iShutdown_N = 1'b1;
    iLatch_Clear = 1'b0; iRail_PG = '0; iRail_Dly = '0;
    for (int i = 0; i < 8; i++) en_hist[i] = '0;
    dly[0] = 1; dly[1] = 2; dly[2] = 0; dly[3] = 3;
    set_dly();

    // Reset values.
    idle(3);
    check("rst en", 32'(oRail_EN), 32'd0);
    check("rst done", 32'(oPwr_Done), 32'd0);
    check("rst fault", 32'(oFault), 32'd0);
    check("rst type", 32'(oFault_Type), 32'd0);
    check("rst rail", 32'(oFault_Rail), 32'd0);
    check("rst state", 32'(oFSM_State), 32'd0);
    iRst = 1'b0;
    step();

    // Directed power-up and power-down with the reference delays.
    power_up();
    idle(3);
    power_down();
    idle(8);

    // PG timeout on rail 1.
    pg_force_low = 4'b0010;
    iPwr_Req = 1'b1;
    wait_en(1, 1'b1);
    e1 = en_rise_cyc[1];
    n = 0;
    while (!oFault && n < 60) begin step(); n++; end
    check("tmo cycle", cyc, e1 + TMO * TD);
    check("tmo en", 32'(oRail_EN), 32'd0);
    check("tmo type", 32'(oFault_Type), 32'd1);
    check("tmo rail", 32'(oFault_Rail), 32'd1);
    check("tmo state", 32'(oFSM_State), 32'd6);
    iPwr_Req = 1'b0; iLatch_Clear = 1'b1;
    step();
    check("tmo clr state", 32'(oFSM_State), 32'd0);
    check("tmo clr fault", 32'(oFault), 32'd0);
    check("tmo clr type", 32'(oFault_Type), 32'd0);
    check("tmo clr rail", 32'(oFault_Rail), 32'd0);
    iLatch_Clear = 1'b0; pg_force_low = '0;
    idle(8);

    // Dropout of rails 2 and 3 together while running.
    power_up();
    idle(2);
    pg_force_low = 4'b1100;
    iRail_PG = iRail_PG & ~pg_force_low;
    step();
    check("drop en", 32'(oRail_EN), 32'd0);
    check("drop fault", 32'(oFault), 32'd1);
    check("drop type", 32'(oFault_Type), 32'd2);
    check("drop rail", 32'(oFault_Rail), 32'd2);
    check("drop state", 32'(oFSM_State), 32'd6);
    iPwr_Req = 1'b0; iLatch_Clear = 1'b1;
    step();
    check("drop clr state", 32'(oFSM_State), 32'd0);
    iLatch_Clear = 1'b0; pg_force_low = '0;
    idle(8);

    // Emergency during ON_PG of rail 1, then a clear with iPwr_Req still high.
    iPwr_Req = 1'b1;
    wait_en(1, 1'b1);
    check("emg pre state", 32'(oFSM_State), 32'd2);
    iShutdown_N = 1'b0;
    step();
    check("emg en", 32'(oRail_EN), 32'd0);
    check("emg fault", 32'(oFault), 32'd1);
    check("emg type", 32'(oFault_Type), 32'd3);
    check("emg rail", 32'(oFault_Rail), 32'd0);
    iLatch_Clear = 1'b1;
    idle(3);
    check("emg hold state", 32'(oFSM_State), 32'd6);
    check("emg hold fault", 32'(oFault), 32'd1);
    iShutdown_N = 1'b1;
    step();
    check("emg clr state", 32'(oFSM_State), 32'd0);
    check("emg clr fault", 32'(oFault), 32'd0);
    check("emg clr type", 32'(oFault_Type), 32'd0);
    iLatch_Clear = 1'b0;
    step();
    check("restart state", 32'(oFSM_State), 32'd1);
    iPwr_Req = 1'b0;
    step();
    check("abort no rail state", 32'(oFSM_State), 32'd0);
    check("abort no rail en", 32'(oRail_EN), 32'd0);
    idle(8);

    // Abort during ON_DLY of rail 2 with rails 0 and 1 up.
    iPwr_Req = 1'b1;
    n = 0;
    while (!(oFSM_State == 4'd1 && oRail_EN == 4'b0011) && n < 200) begin step(); n++; end
    check("abort reach", {24'd0, oFSM_State, oRail_EN}, {24'd0, 4'd1, 4'b0011});
    iPwr_Req = 1'b0;
    a = cyc;
    step();
    check("abort state", 32'(oFSM_State), 32'd4);
    check("abort en", 32'(oRail_EN), 32'b0011);
    wait_en(1, 1'b0);
    check("abort en1 fall", en_fall_cyc[1], a + 1 + dly_cycles(dly[1]));
    wait_pg(1, 1'b0);
    wait_en(0, 1'b0);
    check("abort en0 fall", en_fall_cyc[0], pg_fall_cyc[1] + 1 + dly_cycles(dly[0]));
    wait_pg(0, 1'b0);
    step();
    check("abort idle", 32'(oFSM_State), 32'd0);
    check("abort no fault", 32'(oFault), 32'd0);
    idle(8);

    // Reset in the middle of a power-up.
    iPwr_Req = 1'b1;
    wait_en(1, 1'b1);
    iRst = 1'b1;
    step();
    check("mid rst en", 32'(oRail_EN), 32'd0);
    check("mid rst state", 32'(oFSM_State), 32'd0);
    iRst = 1'b0; iPwr_Req = 1'b0;
    idle(8);

    // Randomised delays and PG lag.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) dly[i] = int'($urandom_range(0, 4));
      pg_lag = int'($urandom_range(1, 4));
      set_dly();
      power_up();
      idle(int'($urandom_range(0, 5)));
      power_down();
      idle(8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwr_seq_nrail.md
Name: pwr_seq_nrail

Overview:
- Parametrised successor to the fixed-rail master power sequencer.
- Sequences NUM_RAILS rails on in ascending index order and off in descending order, each with a per-rail runtime delay and a power-good (PG) handshake.
- Adds what the fixed sequencer lacks: an internal ms tick, PG timeout and dropout fault detection, fault-rail reporting, and aborting a power-up into an orderly power-down.
- Sits under the board top level; the top level maps leak and 48V-fault inputs onto iShutdown_N.

Parameters:
- NUM_RAILS, 4, number of sequenced rails (1..8).
- DLY_W, 16, width of each per-rail delay field, in ticks.
- TICK_DIV, 2000, iClk cycles per tick (1 ms at 2 MHz).
- PG_TMO, 100, ticks allowed for PG to rise (on) or fall (off).

Ports:
- iClk  in  1  module clock.
- iRst  in  1  synchronous active-high reset.
- iAux_Good  in  1  AUX rails good; required to start and to stay up.
- iPwr_Req  in  1  level; 1 = power up, 0 = power down.
- iShutdown_N  in  1  emergency (leak or fault), active low.
- iLatch_Clear  in  1  level; clears the FAULT latch.
- iRail_Dly  in  NUM_RAILS*DLY_W  per-rail pre-delay in ticks; rail k occupies [k*DLY_W +: DLY_W].
- iRail_PG  in  NUM_RAILS  per-rail power good.
- oRail_EN  out  NUM_RAILS  per-rail enable.
- oPwr_Done  out  1  all rails up (RUN state).
- oFault  out  1  fault latched.
- oFault_Type  out  2  00 none, 01 PG timeout, 10 PG dropout, 11 emergency.
- oFault_Rail  out  3  rail index of the fault; 0 for emergency.
- oFSM_State  out  4  current state encoding.

Behaviour:
- Reset: all outputs 0; state IDLE; tick prescaler and delay counter cleared. Asserting reset mid-sequence drops every enable on the next edge.
- Tick prescaler: restarts at 0 on every state entry and pulses every TICK_DIV cycles. A delay of D ticks is therefore exactly D*TICK_DIV cycles after entry; D=0 exits on the cycle after entry.
- States, with encodings: IDLE=0, ON_DLY=1, ON_PG=2, RUN=3, OFF_DLY=4, OFF_PG=5, FAULT=6. Index register k.
- IDLE: when iAux_Good & iPwr_Req & iShutdown_N, set k=0 and go to ON_DLY.
- ON_DLY: wait iRail_Dly[k] ticks. Then set oRail_EN[k]=1 and go to ON_PG.
- ON_PG: when iRail_PG[k]=1, go to ON_DLY with k+1; after rail NUM_RAILS-1, go to RUN. If PG_TMO ticks pass without PG, fault type 01 with rail k.
- RUN: oPwr_Done=1, registered, high in the same cycles as oFSM_State=3. When iPwr_Req=0, set k=NUM_RAILS-1, clear oPwr_Done, and go to OFF_DLY.
- OFF_DLY: wait iRail_Dly[k] ticks. Then set oRail_EN[k]=0 and go to OFF_PG.
- OFF_PG: when iRail_PG[k]=0, go to OFF_DLY with k-1; after k=0, go to IDLE. If PG_TMO ticks pass with PG still high, fault type 01 with rail k.
- Abort during power-up: iPwr_Req=0 in ON_DLY or ON_PG goes to OFF_DLY with k = highest enabled rail. If no rail is enabled, go to IDLE.
- Dropout: in ON_DLY, ON_PG or RUN, any enabled rail j with iRail_PG[j]=0 (excluding rail k while in ON_PG) is fault type 10. If several rails drop, report the lowest index.
- Emergency: iShutdown_N=0, or iAux_Good=0, in any state other than IDLE or FAULT is fault type 11.
- Fault priority when events coincide: emergency > dropout > timeout.
- On any fault, in the same edge: oRail_EN cleared to 0, oFault=1, type and rail latched, state FAULT.
- FAULT: holds until iLatch_Clear=1 & iShutdown_N=1. Then oFault, oFault_Type and oFault_Rail clear to 0 and the state returns to IDLE. A still-high iPwr_Req then restarts the sequence from rail 0.
- iRail_Dly is sampled live: a change applies to the next rail delay not yet started.

Test Plan (TICK_DIV=4, PG_TMO=5, NUM_RAILS=4, delays 1,2,0,3):
- Power-up: iPwr_Req=1, PG follows EN after 2 cycles.
  - Required: EN[0] at +4 cycles, EN[1] 8 cycles after PG[0], EN[2] the cycle after PG[1], EN[3] 12 cycles after PG[2].
  - Then oPwr_Done=1 and oFSM_State=3.
- Power-down from RUN: iPwr_Req=0.
  - Required: EN[3] drops 12 cycles later, then EN[2], EN[1], EN[0] in that order, each after its delay and the previous PG falling; ends in IDLE.
- PG timeout: PG[1] held low.
  - Required: exactly 20 cycles after EN[1] rises, all EN=0, oFault=1, type=01, rail=1.
  - iLatch_Clear then returns the block to IDLE with fault outputs 0.
- Dropout in RUN: PG[2] and PG[3] forced low on the same cycle.
  - Required: next edge all EN=0, type=10, rail=2.
- Emergency: iShutdown_N=0 during ON_PG(1).
  - Required: next edge EN=0, type=11, rail=0.
  - iLatch_Clear with iShutdown_N still 0 keeps the FAULT state.
- Abort: iPwr_Req=0 during ON_DLY(2) with EN[0..1] high.
  - Required: off sequence starts at rail 1; no fault.
